// File: rtl/lcv_div_rem_seq.sv
// Radix-2 restoring divider/remainder, signed or unsigned; fixed WIDTH+2 cycles accept-to-result.
// One request in flight: inp_ready only in IDLE, result held in DONE until outp_ready.
module lcv_div_rem_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp_valid,
   output logic             inp_ready,
   input  logic [WIDTH-1:0] inp_a,
   input  logic [WIDTH-1:0] inp_b,
   input  logic             inp_signed,
   output logic             outp_valid,
   input  logic             outp_ready,
   output logic [WIDTH-1:0] outp_quot,
   output logic [WIDTH-1:0] outp_rem,
   output logic             outp_div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, quo_q, rem_q;
   logic             sgn_q, q_neg_q, r_neg_q, bz_q;
   logic             a_neg, b_neg, borrow;
   logic [WIDTH:0]   part, diff;

   assign a_neg  = sgn_q & a_q[WIDTH-1];
   assign b_neg  = sgn_q & b_q[WIDTH-1];
   // rem_q < divisor always, so part < 2*divisor and bit WIDTH of diff is the borrow.
   assign part   = {rem_q, quo_q[WIDTH-1]};
   assign diff   = part - {1'b0, b_q};
   assign borrow = diff[WIDTH];

   always_comb begin
      state_d    = state_q;
      inp_ready  = 1'b0;
      outp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            inp_ready = 1'b1;
            if (inp_valid) state_d = PREP;
         end
         PREP: state_d = ITER;
         ITER: if (cnt_q == LAST) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: begin
            outp_valid = 1'b1;
            if (outp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         a_q              <= '0;
         b_q              <= '0;
         quo_q            <= '0;
         rem_q            <= '0;
         sgn_q            <= 1'b0;
         q_neg_q          <= 1'b0;
         r_neg_q          <= 1'b0;
         bz_q             <= 1'b0;
         outp_quot        <= '0;
         outp_rem         <= '0;
         outp_div_by_zero <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (inp_valid) begin
                  a_q   <= inp_a;
                  b_q   <= inp_b;
                  sgn_q <= inp_signed;
               end
            end
            // a_q keeps the raw dividend for the divide-by-zero remainder; quo_q doubles as dividend shifter.
            PREP: begin
               quo_q   <= a_neg ? -a_q : a_q;
               b_q     <= b_neg ? -b_q : b_q;
               rem_q   <= '0;
               cnt_q   <= '0;
               q_neg_q <= a_neg ^ b_neg;
               r_neg_q <= a_neg;
               bz_q    <= (b_q == '0);
            end
            ITER: begin
               cnt_q <= cnt_q + 1'b1;
               rem_q <= borrow ? part[WIDTH-1:0] : diff[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], ~borrow};
            end
            FIX: begin
               outp_div_by_zero <= bz_q;
               outp_quot        <= bz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
               outp_rem         <= bz_q ? a_q : (r_neg_q ? -rem_q : rem_q);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcv_div_rem_seq.sv
// Directed bench for lcv_div_rem_seq (WIDTH=32) with a scoreboard queue and independent output monitor.
module tb_lcv_div_rem_seq;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         inp_valid = 1'b0;
   logic         inp_ready;
   logic [W-1:0] inp_a = '0;
   logic [W-1:0] inp_b = '0;
   logic         inp_signed = 1'b0;
   logic         outp_valid;
   logic         outp_ready = 1'b1;
   logic [W-1:0] outp_quot;
   logic [W-1:0] outp_rem;
   logic         outp_div_by_zero;

   lcv_div_rem_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .inp_valid(inp_valid), .inp_ready(inp_ready),
      .inp_a(inp_a), .inp_b(inp_b), .inp_signed(inp_signed),
      .outp_valid(outp_valid), .outp_ready(outp_ready),
      .outp_quot(outp_quot), .outp_rem(outp_rem),
      .outp_div_by_zero(outp_div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           acc;
      int           id;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   exp_t sb[$];
   vec_t vt[12];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   seen  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: latency on first sight of a result, contents on handshake, stray valids.
   always @(negedge clk) begin
      if (outp_valid) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL stray_valid: outp_valid=1 at cycle %0d with nothing outstanding", cyc);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               tests++;
               if (cyc - sb[0].acc != LAT) begin
                  fails++;
                  $display("FAIL latency id%0d: got %0d edges, want %0d", sb[0].id, cyc - sb[0].acc, LAT);
               end
            end
            if (outp_ready) begin
               exp_t e;
               e = sb.pop_front();
               seen = 1'b0;
               tests++;
               if (outp_quot !== e.q || outp_rem !== e.r || outp_div_by_zero !== e.z) begin
                  fails++;
                  $display("FAIL result id%0d: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                           e.id, outp_quot, outp_rem, outp_div_by_zero, e.q, e.r, e.z);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Offers a request, waits (bounded) for the accept, then scrambles the inputs.
   task automatic issue(input vec_t v, input bit push, input int id, output int acc);
      int n = 0;
      @(negedge clk);
      inp_valid  = 1'b1;
      inp_a      = v.a;
      inp_b      = v.b;
      inp_signed = v.s;
      while (!inp_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!inp_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout id%0d: inp_ready=%b after %0d cycles, want 1", id, inp_ready, n);
         inp_valid = 1'b0;
         acc = -1;
      end else begin
         acc = cyc + 1;
         if (push) sb.push_back('{q: v.q, r: v.r, z: v.z, acc: acc, id: id});
         @(posedge clk);
         #1;
         inp_valid  = 1'b0;
         inp_a      = $urandom;
         inp_b      = $urandom;
         inp_signed = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc, acc_y, rel;
      vec_t vx, vy;

      vt[0]  = '{a: 32'd100,        b: 32'd7,          s: 1'b0, q: 32'd14,         r: 32'd2,          z: 1'b0};
      vt[1]  = '{a: 32'hFFFFFFF9,   b: 32'd2,          s: 1'b1, q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   z: 1'b0};
      vt[2]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   s: 1'b1, q: 32'hFFFFFFFD,   r: 32'd1,          z: 1'b0};
      vt[3]  = '{a: 32'd5,          b: 32'd0,          s: 1'b0, q: 32'hFFFFFFFF,   r: 32'd5,          z: 1'b1};
      vt[4]  = '{a: 32'hFFFFFFFB,   b: 32'd0,          s: 1'b1, q: 32'hFFFFFFFF,   r: 32'hFFFFFFFB,   z: 1'b1};
      vt[5]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   s: 1'b1, q: 32'h80000000,   r: 32'd0,          z: 1'b0};
      vt[6]  = '{a: 32'hFFFFFFFF,   b: 32'h10,         s: 1'b0, q: 32'h0FFFFFFF,   r: 32'hF,          z: 1'b0};
      vt[7]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   s: 1'b0, q: 32'd0,          r: 32'h80000000,   z: 1'b0};
      vt[8]  = '{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   s: 1'b1, q: 32'd14,         r: 32'hFFFFFFFE,   z: 1'b0};
      vt[9]  = '{a: 32'd7,          b: 32'd7,          s: 1'b0, q: 32'd1,          r: 32'd0,          z: 1'b0};
      vt[10] = '{a: 32'd3,          b: 32'd10,         s: 1'b0, q: 32'd0,          r: 32'd3,          z: 1'b0};
      vt[11] = '{a: 32'd0,          b: 32'd5,          s: 1'b1, q: 32'd0,          r: 32'd0,          z: 1'b0};
      vx     = '{a: 32'd1000,       b: 32'd3,          s: 1'b0, q: 32'd333,        r: 32'd1,          z: 1'b0};
      vy     = '{a: 32'hFFFFFC18,   b: 32'd3,          s: 1'b1, q: 32'hFFFFFEB3,   r: 32'hFFFFFFFF,   z: 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", W'(outp_valid), '0);
      check("rst_quot", outp_quot, '0);
      check("rst_rem", outp_rem, '0);
      check("rst_dbz", W'(outp_div_by_zero), '0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_inp_ready", W'(inp_ready), W'(1));

      for (int i = 0; i < 12; i++) issue(vt[i], 1'b1, i, acc);
      wait_empty();

      // Backpressure: hold result 10 cycles while the next request waits
      outp_ready = 1'b0;
      issue(vx, 1'b1, 100, acc);
      rel = 0;
      fork
         issue(vy, 1'b1, 101, acc_y);
         begin
            int n = 0;
            while (!outp_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            for (int i = 0; i < 10; i++) begin
               check("hold_valid", W'(outp_valid), W'(1));
               check("hold_inp_ready", W'(inp_ready), '0);
               check("hold_quot", outp_quot, vx.q);
               check("hold_rem", outp_rem, vx.r);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            outp_ready = 1'b1;
            rel = cyc;
         end
      join
      check("accept_after_release", W'(acc_y), W'(rel + 2));
      wait_empty();

      // Reset in the 10th ITER cycle aborts with no result
      issue(vx, 1'b0, 200, acc);
      while (cyc < acc + 10) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_valid", W'(outp_valid), '0);
      check("abort_quot", outp_quot, '0);
      check("abort_rem", outp_rem, '0);
      check("abort_dbz", W'(outp_div_by_zero), '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_inp_ready", W'(inp_ready), W'(1));
      repeat (60) @(negedge clk);

      // Recovery after abort
      issue(vx, 1'b1, 300, acc);
      wait_empty();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
